i2c_codec_responder: RTL and testbench



---
 rtl/i2c_codec_pkg.sv | 38 +++
 rtl/i2c_bus_sync.sv | 64 ++++++
 rtl/i2c_codec_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_codec_pkg.sv
// rtl/i2c_codec_pkg.sv - shared types, constants and register defaults for the codec I2C responder
// Read-back states exist only when I2C_CODEC_RESP_READ_EN is defined.
package i2c_codec_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
    localparam logic [6:0] SW_RESET_REG     = 7'h0F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_BYTE0,
        ST_ACK_0,
        ST_BYTE1,
        ST_ACK_1,
        ST_IGNORE
`ifdef I2C_CODEC_RESP_READ_EN
        ,
        ST_RD_HI,
        ST_RACK_HI,
        ST_RD_LO,
        ST_RACK_LO
`endif
    } state_e;

    function automatic logic [8:0] reg_default(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1: return 9'h097;
            4'd2, 4'd3: return 9'h079;
            4'd4:       return 9'h00A;
            4'd5:       return 9'h008;
            4'd6:       return 9'h09F;
            4'd7:       return 9'h00A;
            default:    return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers with registered edge, START and STOP pulses
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   sda_q, sda_d;
    logic [3:0]             evt_q, evt_d;
    logic                   scl_s, sda_s, scl_chg;

    // An SCL edge in the same cycle as an SDA edge is a data change, never START/STOP.
    always_comb begin
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_chg    = scl_s ^ scl_prev_q;
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        sda_d      = sda_s;
        evt_d[0]   = scl_s & ~scl_prev_q;
        evt_d[1]   = ~scl_s & scl_prev_q;
        evt_d[2]   = scl_s & ~scl_chg & sda_prev_q & ~sda_s;
        evt_d[3]   = scl_s & ~scl_chg & ~sda_prev_q & sda_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            sda_q      <= 1'b1;
            evt_q      <= '0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            sda_q      <= sda_d;
            evt_q      <= evt_d;
        end
    end

    assign sda       = sda_q;
    assign scl_rise  = evt_q[0];
    assign scl_fall  = evt_q[1];
    assign start_det = evt_q[2];
    assign stop_det  = evt_q[3];

endmodule

// File: rtl/i2c_codec_responder.sv
// rtl/i2c_codec_responder.sv - write-only codec control-port I2C target with shadow register file
// Define I2C_CODEC_RESP_READ_EN to add the two-byte register read-back path.
module i2c_codec_responder
    import i2c_codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat_in,
    output logic       i2c_sdat_oe,
    output logic       reg_wr_stb,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    input  logic [3:0] mon_addr,
    output logic [8:0] mon_data,
    output logic       busy,
    output logic [7:0] nack_cnt
);

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic       data8_q, data8_d;
    logic       extra_q, extra_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       wr_stb_q, wr_stb_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic [7:0] nack_cnt_q, nack_cnt_d;
    logic       nack_inc;
    logic [8:0] regs_q [16];
    logic [8:0] regs_d [16];
`ifdef I2C_CODEC_RESP_READ_EN
    logic       rd_q, rd_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rd_hi_byte, rd_lo_byte;

    assign rd_hi_byte = {reg_addr_q, regs_q[reg_addr_q[3:0]][8]};
    assign rd_lo_byte = regs_q[reg_addr_q[3:0]][7:0];
`endif

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (i2c_sclk),
        .sda_in   (i2c_sdat_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        data8_d    = data8_q;
        extra_d    = extra_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        nack_inc   = 1'b0;
`ifdef I2C_CODEC_RESP_READ_EN
        rd_d       = rd_q;
        tx_d       = tx_q;
`endif
        if (stop_det) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            busy_d    = 1'b1;
            oe_d      = 1'b0;
            bit_cnt_d = 3'd0;
            extra_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE0, ST_BYTE1: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        // On the 8th bit the full byte is {shift_q, sda}.
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (shift_q == DEV_ADDR && !sda) begin
                                    state_d = ST_ACK_A;
`ifdef I2C_CODEC_RESP_READ_EN
                                    rd_d    = 1'b0;
                                end else if (shift_q == DEV_ADDR) begin
                                    state_d = ST_ACK_A;
                                    rd_d    = 1'b1;
`endif
                                end else begin
                                    state_d  = ST_IGNORE;
                                    nack_inc = 1'b1;
                                end
                            end else if (state_q == ST_BYTE0) begin
                                if ({1'b0, shift_q} < NUM_REGS_W) begin
                                    reg_addr_d = shift_q;
                                    data8_d    = sda;
                                    state_d    = ST_ACK_0;
                                end else begin
                                    state_d  = ST_IGNORE;
                                    nack_inc = 1'b1;
                                end
                            end else if (extra_q) begin
                                state_d  = ST_IGNORE;
                                nack_inc = 1'b1;
                            end else begin
                                wr_stb_d  = 1'b1;
                                wr_addr_d = reg_addr_q;
                                wr_data_d = {data8_q, shift_q, sda};
                                state_d   = ST_ACK_1;
                            end
                        end
                    end
                end
                ST_ACK_A, ST_ACK_0, ST_ACK_1: begin
                    // bit_cnt 0: waiting for the fall that ends bit 8; 1: ACK driven.
                    if (scl_fall && bit_cnt_q == 3'd0) begin
                        oe_d      = 1'b1;
                        bit_cnt_d = 3'd1;
                    end else if (scl_fall) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (state_q == ST_ACK_A) begin
                            state_d = ST_BYTE0;
`ifdef I2C_CODEC_RESP_READ_EN
                            if (rd_q) begin
                                state_d = ST_RD_HI;
                                tx_d    = rd_hi_byte;
                                oe_d    = ~rd_hi_byte[7];
                            end
`endif
                        end else if (state_q == ST_ACK_0) begin
                            state_d = ST_BYTE1;
                        end else begin
                            state_d = ST_BYTE1;
                            extra_d = 1'b1;
                        end
                    end
                end
`ifdef I2C_CODEC_RESP_READ_EN
                ST_RD_HI, ST_RD_LO: begin
                    if (scl_fall && bit_cnt_q == 3'd7) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = (state_q == ST_RD_HI) ? ST_RACK_HI : ST_RACK_LO;
                    end else if (scl_fall) begin
                        tx_d      = {tx_q[6:0], 1'b1};
                        oe_d      = ~tx_q[6];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_RACK_HI: begin
                    if (scl_rise) begin
                        if (sda) state_d = ST_IGNORE;
                        else     bit_cnt_d = 3'd1;
                    end else if (scl_fall && bit_cnt_q == 3'd1) begin
                        state_d   = ST_RD_LO;
                        bit_cnt_d = 3'd0;
                        tx_d      = rd_lo_byte;
                        oe_d      = ~rd_lo_byte[7];
                    end
                end
                ST_RACK_LO: begin
                    if (scl_rise) state_d = ST_IGNORE;
                end
`endif
                default: ;
            endcase
        end
        nack_cnt_d = (nack_inc && nack_cnt_q != 8'hFF) ? nack_cnt_q + 8'd1 : nack_cnt_q;
    end

    // The file updates one cycle after the strobe, from the registered write.
    always_comb begin
        regs_d = regs_q;
        if (wr_stb_q) begin
            if (wr_addr_q == SW_RESET_REG) begin
                for (int i = 0; i < 16; i++) regs_d[i] = reg_default(4'(i));
            end else begin
                regs_d[wr_addr_q[3:0]] = wr_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            reg_addr_q <= 7'd0;
            data8_q    <= 1'b0;
            extra_q    <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 9'd0;
            nack_cnt_q <= 8'd0;
            for (int i = 0; i < 16; i++) regs_q[i] <= reg_default(4'(i));
`ifdef I2C_CODEC_RESP_READ_EN
            rd_q       <= 1'b0;
            tx_q       <= 8'hFF;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            data8_q    <= data8_d;
            extra_q    <= extra_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            nack_cnt_q <= nack_cnt_d;
            regs_q     <= regs_d;
`ifdef I2C_CODEC_RESP_READ_EN
            rd_q       <= rd_d;
            tx_q       <= tx_d;
`endif
        end
    end

    assign i2c_sdat_oe = oe_q;
    assign reg_wr_stb  = wr_stb_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign mon_data    = regs_q[mon_addr];
    assign busy        = busy_q;
    assign nack_cnt    = nack_cnt_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb/tb_i2c_codec_responder.sv - directed self-checking bench for i2c_codec_responder
module tb_i2c_codec_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_line;
    logic       i2c_sdat_oe;
    logic       reg_wr_stb;
    logic [6:0] reg_wr_addr;
    logic [8:0] reg_wr_data;
    logic [3:0] mon_addr = 4'd0;
    logic [8:0] mon_data;
    logic       busy;
    logic [7:0] nack_cnt;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int oe_cycles = 0;

    logic [8:0] dflt [16] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
                              9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};

    assign sda_line = sda_drv & ~i2c_sdat_oe;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_stb) stb_cnt++;
        if (i2c_sdat_oe) oe_cycles++;
    end

    i2c_codec_responder dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_sclk   (scl_drv),
        .i2c_sdat_in(sda_line),
        .i2c_sdat_oe(i2c_sdat_oe),
        .reg_wr_stb (reg_wr_stb),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .mon_addr   (mon_addr),
        .mon_data   (mon_data),
        .busy       (busy),
        .nack_cnt   (nack_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_mon(input string tag, input logic [3:0] a, input logic [8:0] exp);
        mon_addr = a;
        #1;
        check(tag, 16'(mon_data), 16'(exp));
    endtask

    task automatic quarter();
        repeat (5) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; scl_drv = 1'b1; quarter();
        sda_drv = 1'b0; quarter();
        scl_drv = 1'b0; quarter();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; quarter();
        scl_drv = 1'b1; quarter();
        sda_drv = 1'b1; quarter();
        quarter();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_drv = b; quarter();
        scl_drv = 1'b1; quarter();
        s = sda_line; quarter();
        scl_drv = 1'b0; quarter();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(~ack, s);
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [8:0] d, output logic [2:0] acks);
        bus_start();
        send_byte(8'h34, acks[2]);
        send_byte({a, d[8]}, acks[1]);
        send_byte(d[7:0], acks[0]);
        bus_stop();
    endtask

    initial begin
        logic [2:0] acks;
        logic       a;
        logic       s;
        logic [7:0] b0;
        logic [7:0] b1;
        int         stb0;
        int         oe0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_oe", 16'(i2c_sdat_oe), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_stb", 16'(reg_wr_stb), 16'h0);
        check("rst_wr_addr", 16'(reg_wr_addr), 16'h0);
        check("rst_wr_data", 16'(reg_wr_data), 16'h0);
        check("rst_nack", 16'(nack_cnt), 16'h0);
        check_mon("rst_reg6", 4'd6, 9'h09F);

        // write reg 6 = 0x000
        stb0 = stb_cnt;
        bus_start();
        send_byte(8'h34, acks[2]);
        send_byte(8'h0C, acks[1]);
        send_byte(8'h00, acks[0]);
        check("busy_in_xfer", 16'(busy), 16'h1);
        bus_stop();
        check("w6_acks", 16'(acks), 16'h7);
        check("w6_busy_after", 16'(busy), 16'h0);
        check("w6_stb", 16'(stb_cnt - stb0), 16'h1);
        check("w6_addr", 16'(reg_wr_addr), 16'h6);
        check("w6_data", 16'(reg_wr_data), 16'h0);
        check_mon("w6_mon", 4'd6, 9'h000);

        // address mismatch
        oe0 = oe_cycles;
        bus_start();
        send_byte(8'h36, a);
        bus_stop();
        check("badaddr_ack", 16'(a), 16'h0);
        check("badaddr_oe", 16'(oe_cycles - oe0), 16'h0);
        check("badaddr_nack", 16'(nack_cnt), 16'h1);
        check_mon("badaddr_reg6", 4'd6, 9'h000);

        // reg 4 then software reset
        stb0 = stb_cnt;
        write_reg(7'd4, 9'h012, acks);
        check("w4_acks", 16'(acks), 16'h7);
        check_mon("w4_mon", 4'd4, 9'h012);
        write_reg(7'd15, 9'h000, acks);
        check("swrst_acks", 16'(acks), 16'h7);
        check("swrst_stb", 16'(stb_cnt - stb0), 16'h2);
        check("swrst_addr", 16'(reg_wr_addr), 16'hF);
        for (int i = 0; i < 16; i++) check_mon($sformatf("dflt_%0d", i), 4'(i), dflt[i]);

        // STOP in the middle of BYTE1
        stb0 = stb_cnt;
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h08, a);
        b0 = 8'h12;
        for (int i = 7; i >= 4; i--) bus_bit(b0[i], s);
        bus_stop();
        check("partial_stb", 16'(stb_cnt - stb0), 16'h0);
        check("partial_busy", 16'(busy), 16'h0);
        check_mon("partial_reg4", 4'd4, 9'h00A);

        // register address out of range
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h20, a);
        bus_stop();
        check("range_ack", 16'(a), 16'h0);
        check("range_nack", 16'(nack_cnt), 16'h2);

        // byte after ACK_1
        bus_start();
        send_byte(8'h34, acks[2]);
        send_byte(8'h02, acks[1]);
        send_byte(8'h55, acks[0]);
        send_byte(8'hFF, a);
        bus_stop();
        check("extra_acks", 16'(acks), 16'h7);
        check("extra_ack", 16'(a), 16'h0);
        check("extra_nack", 16'(nack_cnt), 16'h3);
        check_mon("extra_reg1", 4'd1, 9'h055);

        // read-back
        write_reg(7'd7, 9'h1A5, acks);
        check_mon("w7_mon", 4'd7, 9'h1A5);
        bus_start();
        send_byte(8'h35, a);
`ifdef I2C_CODEC_RESP_READ_EN
        check("rd_addr_ack", 16'(a), 16'h1);
        recv_byte(1'b1, b0);
        recv_byte(1'b0, b1);
        bus_stop();
        check("rd_byte_hi", 16'(b0), 16'h0F);
        check("rd_byte_lo", 16'(b1), 16'hA5);
        check("rd_nack", 16'(nack_cnt), 16'h3);
`else
        bus_stop();
        check("rd_addr_ack", 16'(a), 16'h0);
        check("rd_nack", 16'(nack_cnt), 16'h4);
`endif

        // reset while ACK_0 is pulling SDA low
        bus_start();
        send_byte(8'h34, a);
        b0 = 8'h08;
        for (int i = 7; i >= 0; i--) bus_bit(b0[i], s);
        sda_drv = 1'b1;
        quarter();
        check("ack0_oe", 16'(i2c_sdat_oe), 16'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ack0_oe", 16'(i2c_sdat_oe), 16'h0);
        check("rst_ack0_busy", 16'(busy), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        scl_drv = 1'b1;
        quarter();
        check("rst_ack0_nack", 16'(nack_cnt), 16'h0);
        check_mon("rst_ack0_reg7", 4'd7, 9'h00A);
        check("rst_ack0_idle_oe", 16'(i2c_sdat_oe), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
